// File: rtl/pipeline_regs_pkg.sv
// Shared types and helpers for pipeline latch blocks.
// Provides the occupancy-width function and performance counter width used by pipe_chain.
package pipeline_regs_pkg;

    localparam int PERF_CNT_W = 32;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a WIDTH-bit payload register.
// Flush clears valid regardless of load; data only moves on a real transfer.
module pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= src_valid;
            if (load && src_valid)
                data <= src_data;
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// Elastic DEPTH-stage valid/ready pipeline with per-stage flush and bubble collapsing.
// Define PIPE_CHAIN_PERF_EN to add the saturating stall_cnt / drop_cnt counters.
module pipe_chain
    import pipeline_regs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    input  logic [DEPTH-1:0]            flush,
    output logic [occ_width(DEPTH)-1:0] occupancy
`ifdef PIPE_CHAIN_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]       stall_cnt,
    output logic [PERF_CNT_W-1:0]       drop_cnt
`endif
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] data     [DEPTH];
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [OCC_W-1:0] occ_sum;

    // Ready ripples back from the output so an empty slot anywhere lets upstream advance.
    always_comb begin
        rdy            = '0;
        rdy[DEPTH-1]   = !valid[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--)
            rdy[i] = !valid[i] | rdy[i+1];
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign src_valid[g] = in_valid;
            assign src_data[g]  = in_data;
        end else begin : g_body
            assign src_valid[g] = valid[g-1];
            assign src_data[g]  = data[g-1];
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .CLK       (CLK),
            .RST       (RST),
            .load      (rdy[g]),
            .flush     (flush[g]),
            .src_valid (src_valid[g]),
            .src_data  (src_data[g]),
            .valid     (valid[g]),
            .data      (data[g])
        );
    end

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++)
            occ_sum = occ_sum + OCC_W'(valid[i]);
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];
    assign occupancy = occ_sum;

`ifdef PIPE_CHAIN_PERF_EN
    logic [DEPTH-1:0]      next_valid;
    logic [DEPTH-1:0]      killed;
    logic [OCC_W-1:0]      kill_cnt;
    logic [PERF_CNT_W:0]   drop_sum;

    // Count only items that would have been valid after the edge had flush not hit them.
    always_comb begin
        kill_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            next_valid[i] = rdy[i] ? src_valid[i] : valid[i];
            killed[i]     = flush[i] & next_valid[i];
            kill_cnt      = kill_cnt + OCC_W'(killed[i]);
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + (PERF_CNT_W + 1)'(kill_cnt);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            drop_cnt <= drop_sum[PERF_CNT_W] ? '1 : drop_sum[PERF_CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed scoreboard bench for pipe_chain (DEPTH=4, WIDTH=32).
// Accepted items are queued on the input handshake and compared on the output handshake.
module tb_pipe_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [DEPTH-1:0] flush;
    logic [2:0]       occupancy;
`ifdef PIPE_CHAIN_PERF_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      drop_cnt;
`endif

    pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef PIPE_CHAIN_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    logic [WIDTH-1:0] q[$];
    int passed    = 0;
    int total     = 0;
    int fails     = 0;
    int extra_out = 0;
    bit discard   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample both handshakes just before the edge, then advance one cycle.
    task automatic tick();
        #1;
        if (in_valid && in_ready && !discard)
            q.push_back(in_data);
        if (out_valid && out_ready) begin
            if (q.size() == 0)
                extra_out++;
            else
                check("out_data", out_data, q.pop_front());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0 && !out_valid)
                break;
            tick();
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        check("drain_occ", 32'(occupancy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_out;
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_occ", 32'(occupancy), 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Reset mid-stream discards everything.
        in_valid = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            in_data = 32'(v);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("pre_rst_occ", 32'(occupancy), 32'd3);
        #2;
        RST = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_occ", 32'(occupancy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        RST = 1'b0;
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("post_rst_no_item", 32'(extra_out), 32'd0);

        // Streaming with out_ready held high.
        first_out = -1;
        for (int k = 0; k < 14; k++) begin
            in_valid = (k < 8);
            in_data  = 32'(k + 1);
            #1;
            if (out_valid && first_out < 0)
                first_out = k;
            if (k >= 4 && k < 8)
                check("stream_occ", 32'(occupancy), 32'd4);
            tick();
        end
        in_valid = 1'b0;
        check("stream_latency", 32'(first_out), 32'd4);
        drain(10);
        check("stream_extra", 32'(extra_out), 32'd0);

        // Backpressure: four fit, the fifth stalls.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            in_data = 32'(v);
            tick();
        end
        in_data = 32'h5;
        #1;
        check("bp_accepted", 32'(q.size()), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_occ", 32'(occupancy), 32'd4);
        for (int i = 0; i < 3; i++) tick();
        check("bp_stall_in_ready", 32'(in_ready), 32'd0);
`ifdef PIPE_CHAIN_PERF_EN
        check("bp_stall_cnt", stall_cnt, 32'd3);
`endif
        out_ready = 1'b1;
        tick();
        in_data = 32'h6;
        tick();
        in_valid = 1'b0;
        drain(10);
        check("bp_extra", 32'(extra_out), 32'd0);

        // Bubble collapse: two items separated by idle cycles pack at the tail.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 32'hB;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("bubble_occ", 32'(occupancy), 32'd2);
        check("bubble_in_ready", 32'(in_ready), 32'd1);
        check("bubble_out_valid", 32'(out_valid), 32'd1);
        check("bubble_head", out_data, 32'hA);

        // Flush the two youngest stages of a full pipe.
        in_valid = 1'b1;
        in_data  = 32'hC;
        tick();
        in_data = 32'hD;
        tick();
        in_valid = 1'b0;
        #1;
        check("full_occ", 32'(occupancy), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        flush = 4'b0011;
        tick();
        flush = '0;
        check("flush_occ", 32'(occupancy), 32'd2);
        void'(q.pop_back());
        void'(q.pop_back());
`ifdef PIPE_CHAIN_PERF_EN
        check("flush_drop_cnt", drop_cnt, 32'd2);
`endif
        out_ready = 1'b1;
        drain(10);
        check("flush_extra", 32'(extra_out), 32'd0);

        // Accept into stage 0 while flushing it: handshake completes, item vanishes.
        in_valid = 1'b1;
        in_data  = 32'h55;
        flush    = 4'b0001;
        discard  = 1'b1;
        #1;
        check("acc_flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        discard  = 1'b0;
        in_valid = 1'b0;
        flush    = '0;
        check("acc_flush_occ", 32'(occupancy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("acc_flush_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        check("acc_flush_extra", 32'(extra_out), 32'd0);
`ifdef PIPE_CHAIN_PERF_EN
        check("acc_flush_drop_cnt", drop_cnt, 32'd3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised elastic pipeline of DEPTH register stages, WIDTH bits each, with valid/ready handshakes at both ends, per-stage flush and bubble collapsing. It generalises the fixed IF/ID/EX/MEM latches with a single enable/flush pair into one reusable block. It is the building block for the next datapath's decoupled stages: fetch queue, multi-cycle execute units and memory-response paths.

## Interface
- WIDTH, 32, payload bits per stage
- DEPTH, 4, number of register stages (≥1)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream has an item
- in_ready  out  1  stage 0 can accept an item this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  last stage holds a valid item
- out_ready  in  1  downstream accepts this cycle
- out_data  out  WIDTH  last-stage payload
- flush  in  DEPTH  bit i invalidates stage i (bit 0 is the youngest stage)
- occupancy  out  $clog2(DEPTH+1)  count of valid stages
- stall_cnt  out  32  present only with PIPE_CHAIN_PERF_EN
- drop_cnt  out  32  present only with PIPE_CHAIN_PERF_EN

## Operation
- Each stage i holds valid[i] and data[i]. Stage 0 is the youngest; stage DEPTH-1 drives out_valid/out_data.
- Per-stage ready: rdy[DEPTH-1] = !valid[DEPTH-1] | out_ready; rdy[i] = !valid[i] | rdy[i+1]. in_ready = rdy[0]. The ready chain is combinational, so bubbles collapse.
- Stage i loads from stage i-1 (or from in_data for i=0) when rdy[i] is high. Its new valid is the source valid.
- Stage i holds its contents when rdy[i] is low.
- flush[i] forces valid[i] to 0 at the edge. Flush overrides both load and hold.
  - An upstream handshake into a flushed stage still completes. The item is discarded.
  - in_ready is not gated by flush.
- Data registers load only on an actual transfer. Invalid stages keep stale data. out_data is undefined while out_valid is 0, and benches must not check it then.
- occupancy = popcount(valid). It is combinational from the registered valid bits.
- Reset values (asynchronous, immediate on RST rising):
  - valid = 0 and data = 0 in every stage.
  - Outputs: out_valid 0, out_data 0, in_ready 1, occupancy 0, counters 0.
- Reset asserted mid-stream discards all items. The first accept after release is the first accept of a new stream.

## Timing
- Latency: an item accepted at the end of cycle 0 is presented on out_* in cycle DEPTH, given no backpressure.
- Throughput: one item per cycle when out_ready is held high.
- Full: all valid with out_ready=0 gives in_ready=0 in the same cycle.
- Simultaneous events when full:
  - out_ready=1 with in_valid=1: the accept and the emit both occur. Occupancy is unchanged.
  - flush[DEPTH-1] with out_ready=1: the handshake at the output completes and the item counts as delivered. The bench must treat flush on the last stage as observable only when out_ready=0.
- DEPTH=1: a single register. in_ready = !valid | out_ready.

## Configuration
- PIPE_CHAIN_PERF_EN defined: adds stall_cnt and drop_cnt. Both are 32-bit, saturating, and reset to 0.
  - stall_cnt increments on each cycle with in_valid & !in_ready.
  - drop_cnt increments by popcount(flush & next_valid_before_flush) each edge, i.e. the number of items actually killed.
- PIPE_CHAIN_PERF_EN undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- A function for the occupancy width, clog2(DEPTH+1), goes in pipeline_regs_pkg, alongside the existing latch structs. Typed payloads are packed into WIDTH by the instantiating datapath.
- Sub-module pipe_stage: one valid/data slot with load/flush inputs, WIDTH-parametrised.
- pipe_chain generates DEPTH pipe_stage instances plus the ready chain, the popcount and the optional counters.

## Test plan
All scenarios use DEPTH=4, WIDTH=32.
- Reset: load 3 items, then pulse RST mid-cycle. Required: out_valid=0, occupancy=0 and in_ready=1 before the next edge. No item emerges afterwards.
- Streaming: push 0x1–0x8 back-to-back with out_ready=1. Required: first out_valid in cycle 4, then 0x1–0x8 in order on consecutive cycles, occupancy steady at 4.
- Backpressure: out_ready=0, offer 0x1–0x6.
  - Required while stalled: exactly 4 accepted, in_ready=0 after the 4th, occupancy=4.
  - Required on release: 0x1–0x6 emerge in order with no loss or duplication. With the macro on, stall_cnt = number of stalled offer cycles.
- Bubble collapse: items 0xA and 0xB separated by 2 idle cycles, out_ready=0. Required: both sit in stages 3 and 2, occupancy=2, in_ready=1.
- Flush: stages 3..0 hold 0xA, 0xB, 0xC, 0xD with out_ready=0; apply flush=4'b0011. Required: occupancy=2; only 0xA and 0xB emerge after out_ready=1. With the macro on, drop_cnt=2.
- Accept plus flush on stage 0: in_valid with 0x55, empty pipe, flush=4'b0001. Required: in_ready=1 during the cycle, 0x55 never appears, occupancy stays 0.
